// File: rtl/wb_write_queue_if.sv
// Bundle of the write-queue request, drain, forwarding and status signals.
// The queue connects through the slave modport; the pipeline/regfile side uses master.
interface wb_write_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Request handshake: a request transfers on a rising edge where in_valid && in_ready;
    // in_reg/in_data must be stable while in_valid is high, and in_ready does not
    // depend on in_valid.
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;

    logic              wr_hold;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;

    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;

    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport slave (
        input  in_valid, in_reg, in_data, wr_hold, ReadRegister1, ReadRegister2,
        output in_ready, RegWrite, WriteRegister, WriteData,
        output fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty, full
    );

    modport master (
        output in_valid, in_reg, in_data, wr_hold, ReadRegister1, ReadRegister2,
        input  in_ready, RegWrite, WriteRegister, WriteData,
        input  fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count, empty, full
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order writeback queue draining onto the register-file write port, with forwarding.
// Optional in-place coalescing of writes to a pending register: WBQ_COALESCE_EN.
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_write_queue_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] X31 = ADDR_W'(31);

    logic [ADDR_W-1:0] r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_alloc;
    logic              w_co_hit;
    logic [PTR_W-1:0]  w_co_idx;
    logic              w_hit1;
    logic              w_hit2;
    logic [PTR_W-1:0]  w_idx1;
    logic [PTR_W-1:0]  w_idx2;

    // Walk occupied entries oldest to youngest so the last match wins.
    function automatic logic [PTR_W:0] find_youngest(input logic [ADDR_W-1:0] a,
                                                     input logic skip_head);
        logic             hit;
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] p;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            p = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && !(skip_head && (i == 0)) &&
                (r_reg[p] == a) && (a != X31)) begin
                hit = 1'b1;
                idx = p;
            end
        end
        return {hit, idx};
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full && (bus.in_reg != X31);
    assign w_pop   = !w_empty && !bus.wr_hold;

`ifdef WBQ_COALESCE_EN
    // The head leaving on this edge must not absorb new data, or that data would be lost.
    assign {w_co_hit, w_co_idx} = find_youngest(bus.in_reg, w_pop);
`else
    assign w_co_hit = 1'b0;
    assign w_co_idx = '0;
`endif

    assign w_alloc = w_push && !w_co_hit;

    always_comb begin
        {w_hit1, w_idx1} = find_youngest(bus.ReadRegister1, 1'b0);
        {w_hit2, w_idx2} = find_youngest(bus.ReadRegister2, 1'b0);
    end

    assign bus.in_ready      = !w_full;
    assign bus.RegWrite      = w_pop;
    assign bus.WriteRegister = w_empty ? '0 : r_reg[r_head];
    assign bus.WriteData     = w_empty ? '0 : r_data[r_head];
    assign bus.fwd_hit1      = w_hit1;
    assign bus.fwd_data1     = w_hit1 ? r_data[w_idx1] : '0;
    assign bus.fwd_hit2      = w_hit2;
    assign bus.fwd_data2     = w_hit2 ? r_data[w_idx2] : '0;
    assign bus.count         = r_count;
    assign bus.empty         = w_empty;
    assign bus.full          = w_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_alloc) r_tail <= r_tail + 1'b1;
            if (w_pop)   r_head <= r_head + 1'b1;
            r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
        end
    end

    // Entry storage carries no reset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_reg[r_tail]  <= bus.in_reg;
            r_data[r_tail] <= bus.in_data;
        end else if (w_push && w_co_hit) begin
            r_data[w_co_idx] <= bus.in_data;
        end
    end
endmodule
